// File: rtl/sdc_pkg.sv
// Shared types and constants for the SPI-mode SD command engine.
// Holds the FSM state enum, the fixed CMD0/CMD8 frames and the CRC7 helper.
package sdc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitR1,
    StRecv,
    StTrail,
    StDone
  } state_e;

  localparam int unsigned FRAME_W    = 48;
  localparam logic [7:0]  R1_FILL    = 8'hFF;
  localparam logic [47:0] CMD0_FRAME = 48'h40_00000000_95;
  localparam logic [47:0] CMD8_FRAME = 48'h48_000001AA_87;

  // CRC7 (x^7 + x^3 + 1) over the command byte and argument, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

endpackage

// File: rtl/sdc_sck_gen.sv
// SCK generator: divides i_clk by 2*CLK_DIV while enabled, SCK idles low.
// o_rise/o_fall strobe in the i_clk cycle whose edge toggles SCK.
module sdc_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic            wrap;

  assign wrap   = i_en && (cnt_q == CntMax);
  assign o_rise = wrap && !o_sck;
  assign o_fall = wrap && o_sck;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      cnt_q <= '0;
      o_sck <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      o_sck <= ~o_sck;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sdc_cmd_engine.sv
// SPI-mode SD command engine: sends a 48-bit frame, polls for R1, captures trailing bytes.
// Define SDC_CRC7_GEN_EN to generate the frame CRC byte internally instead of using i_crc.
module sdc_cmd_engine
  import sdc_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned NCR_MAX   = 8,
  parameter int unsigned MAX_EXTRA = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_cmd,
  input  logic [31:0] i_arg,
  input  logic [7:0]  i_crc,
  input  logic [2:0]  i_extra,
  input  logic        i_miso,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_cs_n,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [7:0]  o_r1,
  output logic [31:0] o_resp
);

  localparam logic [10:0] NcrBits  = 11'(NCR_MAX * 8);
  localparam logic [2:0]  MaxExtra = 3'(MAX_EXTRA);

  state_e             state_q;
  logic [FRAME_W-1:0] sh_q;
  logic [5:0]         bit_cnt_q;
  logic [10:0]        ncr_cnt_q;
  logic [2:0]         extra_q;
  logic               r1_act_q;
  logic [7:0]         r1_sh_q;
  logic [31:0]        resp_sh_q;

  logic       sck_en, rise, fall;
  logic [7:0] crc_byte;
  logic [2:0] extra_clamped;

`ifdef SDC_CRC7_GEN_EN
  logic unused_crc;
  assign unused_crc = ^i_crc;
  assign crc_byte   = {crc7({i_cmd, i_arg}), 1'b1};
`else
  assign crc_byte = i_crc;
`endif

  assign extra_clamped = (i_extra > MaxExtra) ? MaxExtra : i_extra;
  assign sck_en = (state_q == StSend) || (state_q == StWaitR1) ||
                  (state_q == StRecv) || (state_q == StTrail);

  sdc_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (sck_en),
    .o_sck  (o_sck),
    .o_rise (rise),
    .o_fall (fall)
  );

  // Sampling happens on rising ticks; state changes only on falling ticks so each
  // phase spans whole SCK periods.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      ncr_cnt_q <= '0;
      extra_q   <= '0;
      r1_act_q  <= 1'b0;
      r1_sh_q   <= '0;
      resp_sh_q <= '0;
      o_mosi    <= 1'b1;
      o_cs_n    <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      o_r1      <= R1_FILL;
      o_resp    <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A start coinciding with the done pulse is dropped.
          if (i_start && !o_done) begin
            sh_q      <= {i_cmd, i_arg, crc_byte};
            o_mosi    <= i_cmd[7];
            extra_q   <= extra_clamped;
            bit_cnt_q <= '0;
            ncr_cnt_q <= '0;
            r1_act_q  <= 1'b0;
            o_cs_n    <= 1'b0;
            o_busy    <= 1'b1;
            o_timeout <= 1'b0;
            o_resp    <= '0;
            state_q   <= StSend;
          end
        end
        StSend: begin
          if (fall) begin
            if (bit_cnt_q == 6'd47) begin
              o_mosi    <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= StWaitR1;
            end else begin
              sh_q      <= sh_q << 1;
              o_mosi    <= sh_q[46];
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end
        end
        StWaitR1: begin
          if (rise) begin
            if (r1_act_q || !i_miso) begin
              r1_sh_q   <= {r1_sh_q[6:0], i_miso};
              r1_act_q  <= 1'b1;
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end else begin
              ncr_cnt_q <= ncr_cnt_q + 11'd1;
            end
          end else if (fall) begin
            if (r1_act_q && bit_cnt_q == 6'd8) begin
              o_r1      <= r1_sh_q;
              bit_cnt_q <= '0;
              resp_sh_q <= '0;
              if (extra_q == 3'd0) begin
                o_cs_n  <= 1'b1;
                state_q <= StTrail;
              end else begin
                state_q <= StRecv;
              end
            end else if (!r1_act_q && ncr_cnt_q == NcrBits) begin
              o_timeout <= 1'b1;
              o_r1      <= R1_FILL;
              bit_cnt_q <= '0;
              o_cs_n    <= 1'b1;
              state_q   <= StTrail;
            end
          end
        end
        StRecv: begin
          if (rise) begin
            resp_sh_q <= {resp_sh_q[30:0], i_miso};
            bit_cnt_q <= bit_cnt_q + 6'd1;
          end else if (fall && bit_cnt_q == {extra_q, 3'b000}) begin
            // Left-justify so the first received byte lands in the MSBs.
            o_resp    <= resp_sh_q << (6'd32 - {extra_q, 3'b000});
            bit_cnt_q <= '0;
            o_cs_n    <= 1'b1;
            state_q   <= StTrail;
          end
        end
        StTrail: begin
          if (fall) begin
            if (bit_cnt_q == 6'd7) begin
              bit_cnt_q <= '0;
              state_q   <= StDone;
            end else begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end
        end
        StDone: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_cmd_engine.sv
// Self-checking bench for sdc_cmd_engine with a byte-aligned SD card model on MISO.
// Build with SDC_CRC7_GEN_EN defined to exercise internal CRC generation.
module tb_sdc_cmd_engine;
  import sdc_pkg::*;

  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned NCR_MAX   = 8;
  localparam int unsigned MAX_EXTRA = 4;
  localparam int          Budget    = 4000;
`ifdef SDC_CRC7_GEN_EN
  localparam logic [7:0] Crc8Exp = 8'h87;
`else
  localparam logic [7:0] Crc8Exp = 8'h00;
`endif

  logic        clk, rst_n, start, miso;
  logic [7:0]  cmd, crc, r1;
  logic [31:0] arg, resp;
  logic [2:0]  extra;
  logic        sck, mosi, cs_n, busy, done, tmo;

  sdc_cmd_engine #(
    .CLK_DIV  (CLK_DIV),
    .NCR_MAX  (NCR_MAX),
    .MAX_EXTRA(MAX_EXTRA)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_cmd    (cmd),
    .i_arg    (arg),
    .i_crc    (crc),
    .i_extra  (extra),
    .i_miso   (miso),
    .o_sck    (sck),
    .o_mosi   (mosi),
    .o_cs_n   (cs_n),
    .o_busy   (busy),
    .o_done   (done),
    .o_timeout(tmo),
    .o_r1     (r1),
    .o_resp   (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Card model: all-ones until byte card_at after the frame, then card_len bytes.
  logic [47:0] card_resp;
  int          card_at, card_len, rcnt;
  logic [47:0] rx_frame;

  function automatic logic miso_for(input int idx);
    int b, j;
    if (idx < 48) return 1'b1;
    b = idx - 48;
    j = b / 8 - card_at;
    if (j < 0 || j >= card_len) return 1'b1;
    return card_resp[47 - j * 8 - b % 8];
  endfunction

  initial begin
    miso = 1'b1;
    rcnt = 0;
    rx_frame = '0;
    forever begin
      @(negedge cs_n);
      rcnt = 0;
      miso = miso_for(0);
      forever begin
        @(posedge sck or posedge cs_n);
        if (cs_n) break;
        if (rcnt < 48) rx_frame = {rx_frame[46:0], mosi};
        rcnt++;
        @(negedge sck or posedge cs_n);
        if (cs_n) break;
        miso = miso_for(rcnt);
      end
      miso = 1'b1;
    end
  end

  int done_cnt = 0;
  int trail_cnt = 0;
  always @(posedge clk) if (done) done_cnt++;
  always @(posedge sck) if (cs_n) trail_cnt++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] arg;
    logic [7:0]  crc;
    logic [2:0]  extra;
    int          resp_at;
    int          resp_len;
    logic [47:0] card;
    logic [47:0] frame;
    logic [7:0]  r1;
    logic [31:0] resp;
    logic        tmo;
    int          cycles;
  } vec_t;

  typedef struct {
    logic [47:0] frame;
    logic [7:0]  r1;
    logic [31:0] resp;
    logic        tmo;
    int          cycles;
  } exp_t;

  exp_t sb_q[$];

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < Budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) begin
      check("done_within_budget", 64'(done), 64'd1);
      cyc = -1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   cyc, t0;
    card_resp = v.card;
    card_at   = v.resp_at;
    card_len  = v.resp_len;
    @(negedge clk);
    cmd   = v.cmd;
    arg   = v.arg;
    crc   = v.crc;
    extra = v.extra;
    start = 1'b1;
    sb_q.push_back('{frame: v.frame, r1: v.r1, resp: v.resp, tmo: v.tmo, cycles: v.cycles});
    t0 = trail_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("cs_low_after_start", 64'(cs_n), 64'd0);
    wait_done(cyc);
    e = sb_q.pop_front();
    check("latency", 64'(cyc), 64'(e.cycles));
    check("r1", 64'(r1), 64'(e.r1));
    check("resp", 64'(resp), 64'(e.resp));
    check("timeout", 64'(tmo), 64'(e.tmo));
    check("frame", 64'(rx_frame), 64'(e.frame));
    check("busy_at_done", 64'(busy), 64'd0);
    check("trailer_clocks", 64'(trail_cnt - t0), 64'd8);
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  vec_t vecs[7];
  int   cyc, d0;

  initial begin
    vecs[0] = '{8'h40, 32'h0, 8'h95, 3'd0, 1, 1, 48'h01_0000000000, CMD0_FRAME,
                8'h01, 32'h0, 1'b0, 290};
    vecs[1] = '{8'h48, 32'h1AA, 8'h87, 3'd4, 1, 5, 48'h01_00_00_01_AA_00, CMD8_FRAME,
                8'h01, 32'h000001AA, 1'b0, 418};
    vecs[2] = '{8'h40, 32'h0, 8'h95, 3'd2, 0, 0, 48'h0, CMD0_FRAME,
                8'hFF, 32'h0, 1'b1, 482};
    vecs[3] = '{8'h69, 32'h40000000, 8'h77, 3'd4, 0, 5, 48'h01_C0_FF_80_00_00,
                48'h69_40000000_77, 8'h01, 32'hC0FF8000, 1'b0, 386};
    vecs[4] = '{8'h77, 32'h0, 8'h65, 3'd2, 2, 3, 48'h05_12_34_000000, 48'h77_00000000_65,
                8'h05, 32'h12340000, 1'b0, 386};
    vecs[5] = '{8'h40, 32'h0, 8'h95, 3'd7, 0, 6, 48'h00_DE_AD_BE_EF_55, CMD0_FRAME,
                8'h00, 32'hDEADBEEF, 1'b0, 386};
    vecs[6] = '{8'h48, 32'h1AA, 8'h00, 3'd0, 7, 1, 48'h01_0000000000,
                {8'h48, 32'h1AA, Crc8Exp}, 8'h01, 32'h0, 1'b0, 482};

    rst_n = 1'b0; start = 1'b0; cmd = '0; arg = '0; crc = '0; extra = '0;
    card_resp = '0; card_at = 0; card_len = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd1);
    check("rst_cs_n", 64'(cs_n), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_timeout", 64'(tmo), 64'd0);
    check("rst_r1", 64'(r1), 64'hFF);
    check("rst_resp", 64'(resp), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Starts while busy and in the done cycle are ignored; the next cycle is accepted.
    card_resp = 48'h01_0000000000; card_at = 1; card_len = 1;
    d0 = done_cnt;
    @(negedge clk);
    cmd = 8'h40; arg = 32'h0; crc = 8'h95; extra = 3'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < Budget) begin
      start = (cyc % 5 == 0);
      cmd = 8'h51; arg = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("busy_start_latency", 64'(cyc), 64'd290);
    check("busy_start_frame", 64'(rx_frame), 64'(CMD0_FRAME));
    start = 1'b1; cmd = 8'h48; arg = 32'h1AA; crc = 8'h87;
    @(posedge clk);
    #1;
    check("start_in_done_ignored", 64'(busy), 64'd0);
    cmd = 8'h77; arg = 32'h0; crc = 8'h65;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_after_done", 64'(busy), 64'd1);
    wait_done(cyc);
    check("second_latency", 64'(cyc), 64'd290);
    check("second_frame", 64'(rx_frame), 64'h77_00000000_65);
    @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - d0), 64'd2);

    // Reset in the middle of SEND aborts without a done pulse.
    d0 = done_cnt;
    @(negedge clk);
    cmd = 8'h40; arg = 32'h0; crc = 8'h95; extra = 3'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cs_n", 64'(cs_n), 64'd1);
    check("abort_sck", 64'(sck), 64'd0);
    check("abort_mosi", 64'(mosi), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdc_cmd_engine.md
Name: sdc_cmd_engine

Overview:
Parametrised SPI-mode SD command engine. It generates its own SCK, shifts out a 48-bit command frame and polls MISO for the R1 start bit within an NCR byte window. It then captures 0..4 trailing response bytes (R3/R7) and releases CS after a trailer byte. It sits between the SD init/read controller and the SPI pads, and adds response capture, timeout and an SCK divider.

Parameters:
CLK_DIV, 4, i_clk cycles per SCK half-period (>=1); SCK frequency = f_clk/(2*CLK_DIV)
NCR_MAX, 8, max 0xFF filler bytes polled before R1 timeout (1..255)
MAX_EXTRA, 4, max trailing response bytes after R1 (0..4)

Ports:
i_clk  in  1  system clock, single domain
i_rst_n  in  1  synchronous reset, active-low
i_start  in  1  one-cycle command request; sampled only in IDLE
i_cmd  in  8  command byte incl. start/transmit bits (e.g. 8'h40|index)
i_arg  in  32  argument
i_crc  in  8  CRC7 plus end bit
i_extra  in  3  trailing bytes to capture (0..MAX_EXTRA; larger values clamp)
i_miso  in  1  card data out
o_sck  out  1  SPI clock, mode 0
o_mosi  out  1  SPI data to card
o_cs_n  out  1  chip select, active-low
o_busy  out  1  high from accepted start until o_done
o_done  out  1  one-cycle pulse at completion
o_timeout  out  1  valid with o_done; no R1 start bit within NCR_MAX bytes
o_r1  out  8  captured R1 (8'hFF on timeout)
o_resp  out  32  trailing bytes, first byte in MSBs, left-justified; unused bits 0

Behaviour:
- Reset (i_rst_n low at posedge): state IDLE; o_sck=0, o_mosi=1, o_cs_n=1, o_busy=0, o_done=0, o_timeout=0, o_r1=8'hFF, o_resp=0, divider and counters cleared. Reset mid-transfer aborts immediately with no o_done.
- Tick: the divider counts 0..CLK_DIV-1. At wrap it toggles SCK in the active states. MOSI updates on the falling tick. MISO is sampled on the rising tick. Idle MOSI is 1.
- IDLE: on i_start, latch {i_cmd,i_arg,i_crc} and i_extra. Assert o_cs_n=0 and o_busy=1 on the next cycle. Go to SEND with MOSI = frame bit 47.
- SEND: 48 SCK periods, MSB first. Then go to WAIT_R1 with MOSI held 1.
- WAIT_R1: clock bytes of 1s. Sample MISO on each rising edge. The first sampled 0 is R1 bit 7; capture 8 bits. If NCR_MAX*8 samples pass without a 0, set o_timeout=1 and o_r1=8'hFF, then go to TRAIL.
- RECV: if extra>0, capture extra*8 bits MSB first into o_resp. Then go to TRAIL.
- TRAIL: raise o_cs_n=1, clock 8 more SCK periods with MOSI=1, then go to DONE.
- DONE: pulse o_done for one cycle, drop o_busy, return to IDLE. o_r1, o_resp and o_timeout hold until the next accepted start, which clears o_resp and o_timeout.
- Latency with CLK_DIV=c, card responding at byte k (0-based), e extra bytes: 1 + 2c*(48 + 8(k+1) + 8e + 8) + 1 cycles to o_done.
- i_start while busy is ignored. i_start in the same cycle as o_done is ignored, so the earliest new start is one cycle after o_done.
- R1 with bit 7 set cannot occur by construction, because the start bit is 0.
- Timeout skips RECV regardless of i_extra.

Optional Feature:
SDC_CRC7_GEN_EN
- Defined: the frame CRC byte is {crc7(i_cmd,i_arg),1'b1}, computed at start by a combinational CRC7 (poly x^7+x^3+1), and i_crc is ignored.
- Undefined: i_crc is sent verbatim. The port exists in both builds.

Decomposition:
- Package sdc_pkg: state enum (IDLE, SEND, WAIT_R1, RECV, TRAIL, DONE), FRAME_W=48, R1_FILL=8'hFF, CMD0_FRAME=48'h40_00000000_95, CMD8_FRAME=48'h48_000001AA_87, crc7 function.
- One sub-module, sdc_sck_gen: divider, SCK toggle, rise/fall tick strobes.
- The shift/capture FSM stays in sdc_cmd_engine.

Test Plan:
- CMD0 frame, CLK_DIV=2; card model answers 8'h01 at byte 1 -> MOSI shows 0x40 00000000 95 MSB-first; o_r1=8'h01, o_timeout=0; o_done at cycle 1+4*(48+16+8)+1=290.
- CMD8 (arg 0x1AA, i_extra=4); card returns 01 then 00 00 01 AA -> o_r1=8'h01, o_resp=32'h000001AA.
- Card silent (MISO=1), NCR_MAX=8 -> o_timeout=1, o_r1=8'hFF, o_resp=0; CS high for 8 trailer clocks, then o_done.
- i_start asserted repeatedly during a transfer and again in the o_done cycle -> exactly one transfer; a start one cycle after o_done is accepted.
- i_rst_n low mid-SEND -> next cycle o_cs_n=1, o_sck=0, o_mosi=1, o_busy=0, no o_done; next command completes normally.
- With SDC_CRC7_GEN_EN, i_crc=8'h00 and CMD8 arg 0x1AA -> transmitted CRC byte is 8'h87.
